// File: rtl/hdc_pkg.sv
// Shared types and helpers for the HDC spam/ham classifier sequencer.
// Holds result codes, the sequencer state type and the byte tokenizer.
package hdc_pkg;

    localparam int NUM_CHAR = 37;
    localparam int IDX_W    = $clog2(NUM_CHAR);

    localparam logic [1:0] RES_HAM  = 2'b01;
    localparam logic [1:0] RES_SPAM = 2'b00;
    localparam logic [1:0] RES_NONE = 2'b11;

    typedef enum logic [2:0] {
        S_LOAD,
        S_ENC,
        S_ENC_DRAIN,
        S_SIM,
        S_SIM_DRAIN,
        S_DECIDE
    } state_t;

    // Case-folded letters map to 11..36, digits to 1..10, anything else to 0
    function automatic logic [IDX_W-1:0] char_to_idx(input logic [7:0] ch);
        logic [IDX_W-1:0] t;
        t = '0;
        if (ch >= 8'h41 && ch <= 8'h5a) begin
            t = IDX_W'(ch - 8'h41 + 8'd11);
        end else if (ch >= 8'h61 && ch <= 8'h7a) begin
            t = IDX_W'(ch - 8'h61 + 8'd11);
        end else if (ch >= 8'h30 && ch <= 8'h39) begin
            t = IDX_W'(ch - 8'h30 + 8'd1);
        end
        return t;
    endfunction

endpackage

// File: rtl/hdc_delay_line.sv
// Fixed-latency valid+tag shift register that aligns control strobes
// with data returning from the external memories.
module hdc_delay_line #(
    parameter int LAT = 2,
    parameter int W   = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         src_valid,
    input  logic [W-1:0] src_tag,
    output logic         dly_valid,
    output logic [W-1:0] dly_tag
);

    logic [LAT-1:0] vld;
    logic [W-1:0]   tag [LAT];

    always_ff @(posedge clk) begin
        if (!reset) begin
            vld <= '0;
            for (int i = 0; i < LAT; i++) begin
                tag[i] <= '0;
            end
        end else begin
            vld[0] <= src_valid;
            tag[0] <= src_tag;
            for (int i = 1; i < LAT; i++) begin
                vld[i] <= vld[i-1];
                tag[i] <= tag[i-1];
            end
        end
    end

    assign dly_valid = vld[LAT-1];
    assign dly_tag   = tag[LAT-1];

endmodule

// File: rtl/hdc_classify_seq.sv
// HDC classifier sequencer: tokenize, encode pass, similarity pass, decide.
// Define HDC_COS_NORM_EN to weight dot products by the opposite prototype norm.
module hdc_classify_seq
    import hdc_pkg::*;
#(
    parameter int MAX_LENGTH = 200,
    parameter int DIM        = 10000,
    parameter int ACC_W      = 16,
    parameter int DOT_W      = 32,
    parameter int IM_LAT     = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [7:0]                 in_char,
    input  logic                       in_last,
    output logic                       im_rd_en,
    output logic [IDX_W-1:0]           im_char_idx,
    output logic [$clog2(DIM)-1:0]     dim_addr,
    output logic                       acc_en,
    output logic                       acc_first,
    output logic                       acc_last,
    input  logic                       acc_out_valid,
    input  logic [ACC_W-1:0]           acc_out,
    output logic                       hv_rd_en,
    output logic [ACC_W+$clog2(DIM):0] thr_sum,
    output logic                       dot_en,
    output logic                       dot_clr,
    input  logic [DOT_W-1:0]           dot_ham,
    input  logic [DOT_W-1:0]           dot_spam,
    input  logic [15:0]                norm_ham,
    input  logic [15:0]                norm_spam,
    output logic [1:0]                 result,
    output logic                       res_valid,
    output logic                       ovf
);

    localparam int DW  = $clog2(DIM);
    localparam int CW  = $clog2(MAX_LENGTH + 1);
    localparam int RW  = $clog2(DIM + 1);
    localparam int TW  = ACC_W + DW + 1;
    localparam int PW  = DOT_W + 17;
    localparam int DRW = $clog2(IM_LAT + 1);

    state_t state, state_nx;

    logic [IDX_W-1:0] buf_mem [MAX_LENGTH];
    logic [CW-1:0]    cnt, len, cidx;
    logic [DW-1:0]    dcnt;
    logic [RW-1:0]    rcv;
    logic [DRW-1:0]   drn;

    logic accept, c_last, d_last, rcv_done, drn_end, clr_tok;
    logic acc_v;
    logic [1:0] acc_tag;
    logic signed [PW-1:0] cmp_a, cmp_b;

    assign accept   = in_valid & in_ready;
    assign c_last   = (cidx == len - CW'(1));
    assign d_last   = (dcnt == DW'(DIM - 1));
    assign rcv_done = (rcv == RW'(DIM));
    assign drn_end  = (drn == DRW'(IM_LAT - 1));

    assign im_char_idx = buf_mem[cidx];
    assign dim_addr    = dcnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= S_LOAD;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        in_ready = 1'b0;
        im_rd_en = 1'b0;
        hv_rd_en = 1'b0;
        clr_tok  = 1'b0;
        unique case (state)
            S_LOAD: begin
                in_ready = 1'b1;
                if (in_valid && in_last) state_nx = S_ENC;
            end
            S_ENC: begin
                im_rd_en = 1'b1;
                if (c_last && d_last) state_nx = S_ENC_DRAIN;
            end
            // The clear token rides the dot delay line one slot ahead of d=0
            S_ENC_DRAIN: begin
                if (rcv_done) begin
                    clr_tok  = 1'b1;
                    state_nx = S_SIM;
                end
            end
            S_SIM: begin
                hv_rd_en = 1'b1;
                if (d_last) state_nx = S_SIM_DRAIN;
            end
            S_SIM_DRAIN: begin
                if (drn_end) state_nx = S_DECIDE;
            end
            S_DECIDE: state_nx = S_LOAD;
            default:  state_nx = S_LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (accept && cnt != CW'(MAX_LENGTH)) begin
            buf_mem[cnt] <= char_to_idx(in_char);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt       <= '0;
            len       <= '0;
            cidx      <= '0;
            dcnt      <= '0;
            rcv       <= '0;
            drn       <= '0;
            thr_sum   <= '0;
            ovf       <= 1'b0;
            result    <= RES_NONE;
            res_valid <= 1'b0;
        end else begin
            res_valid <= 1'b0;
            if (accept) begin
                if (cnt != CW'(MAX_LENGTH)) cnt <= cnt + CW'(1);
                ovf <= (cnt == CW'(MAX_LENGTH)) | (ovf & (cnt != '0));
                if (in_last) begin
                    len     <= (cnt == CW'(MAX_LENGTH)) ? cnt : cnt + CW'(1);
                    cnt     <= '0;
                    cidx    <= '0;
                    dcnt    <= '0;
                    rcv     <= '0;
                    thr_sum <= '0;
                end
            end
            if (im_rd_en) begin
                if (c_last) begin
                    cidx <= '0;
                    dcnt <= d_last ? '0 : dcnt + DW'(1);
                end else begin
                    cidx <= cidx + CW'(1);
                end
            end
            if (hv_rd_en) dcnt <= d_last ? '0 : dcnt + DW'(1);
            if (acc_out_valid && (state == S_ENC || state == S_ENC_DRAIN)) begin
                rcv     <= rcv + RW'(1);
                thr_sum <= thr_sum + {{(TW-ACC_W){acc_out[ACC_W-1]}}, acc_out};
            end
            if (state == S_SIM_DRAIN) drn <= drn_end ? '0 : drn + DRW'(1);
            if (state == S_DECIDE) begin
                res_valid <= 1'b1;
                if (cmp_a > cmp_b)      result <= RES_HAM;
                else if (cmp_a < cmp_b) result <= RES_SPAM;
                else                    result <= RES_NONE;
            end
        end
    end

`ifdef HDC_COS_NORM_EN
    assign cmp_a = PW'($signed(dot_ham))  * PW'($signed({1'b0, norm_spam}));
    assign cmp_b = PW'($signed(dot_spam)) * PW'($signed({1'b0, norm_ham}));
`else
    logic unused_norm;
    assign unused_norm = ^{norm_ham, norm_spam};
    assign cmp_a = PW'($signed(dot_ham));
    assign cmp_b = PW'($signed(dot_spam));
`endif

    hdc_delay_line #(.LAT(IM_LAT), .W(2)) u_acc_dly (
        .clk       (clk),
        .reset     (reset),
        .src_valid (im_rd_en),
        .src_tag   ({cidx == '0, c_last}),
        .dly_valid (acc_v),
        .dly_tag   (acc_tag)
    );

    assign acc_en    = acc_v;
    assign acc_first = acc_v & acc_tag[1];
    assign acc_last  = acc_v & acc_tag[0];

    hdc_delay_line #(.LAT(IM_LAT), .W(1)) u_dot_dly (
        .clk       (clk),
        .reset     (reset),
        .src_valid (hv_rd_en),
        .src_tag   (clr_tok),
        .dly_valid (dot_en),
        .dly_tag   (dot_clr)
    );

endmodule
